// File: rtl/sm_muldiv.sv
// ---------------------------------------------------------------------------
// sm_muldiv -- sequential multiply/divide unit with hi/lo result registers.
//
// Multiplication uses radix-2 shift-add and division uses restoring division,
// both one bit per cycle over WIDTH cycles. hi/lo can also be written directly
// (MTHI/MTLO style) while the unit is idle.
//
// Optional feature macro: SM_MULDIV_SIGNED_EN
//   defined   : oper[1]=1 selects signed MULT/DIV. Magnitudes are processed,
//               then a single FIX cycle applies sign correction.
//   undefined : oper[1] is ignored; every operation is unsigned.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           request an operation (sampled only while busy=0)
//   oper[1:0]       00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   srcA, srcB      multiplicand/dividend, multiplier/divisor
//   hiWe, loWe      direct write of hi / lo from wData while idle
//   wData           direct-write data
//   busy            operation in progress
//   done            one-cycle pulse in the first idle cycle after a result
//   divZero         last completed division had a zero divisor
//   hi, lo          product high/low half, or remainder/quotient
// ---------------------------------------------------------------------------
module sm_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       oper,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             hiWe,
   input  logic             loWe,
   input  logic [WIDTH-1:0] wData,
   output logic             busy,
   output logic             done,
   output logic             divZero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [CW-1:0]    cnt;
   logic             op_div;
   logic             dz_pend;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;

   logic             ld_div;
   logic [WIDTH-1:0] ld_a;
   logic [WIDTH-1:0] ld_b;
   logic             fix_needed;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   logic             unused_bits;

`ifdef SM_MULDIV_SIGNED_EN
   logic             op_signed;
   logic             neg_q;
   logic             neg_r;
   logic             ld_signed;
   logic             ld_a_neg;
   logic             ld_b_neg;
   logic [WIDTH-1:0] fix_hi;
   logic [WIDTH-1:0] fix_lo;
   logic [2*WIDTH-1:0] prod_neg;

   assign fix_needed  = op_signed;
   assign unused_bits = div_diff[WIDTH];
`else
   assign fix_needed  = 1'b0;
   assign unused_bits = ^{div_diff[WIDTH], oper[1]};
`endif

   // Operand preparation at the accepting edge (magnitudes for signed ops)
   always_comb begin
      ld_div = oper[0];
      ld_a   = srcA;
      ld_b   = srcB;
`ifdef SM_MULDIV_SIGNED_EN
      ld_signed = oper[1];
      ld_a_neg  = oper[1] & srcA[WIDTH-1];
      ld_b_neg  = oper[1] & srcB[WIDTH-1];
      if (ld_a_neg) ld_a = -srcA;
      if (ld_b_neg) ld_b = -srcB;
`endif
   end

   // One iteration: shift-add for multiply, restoring step for divide
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opb};
      step_hi   = mul_sum[WIDTH:1];
      step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
      if (op_div) begin
         // No borrow means the divisor fits: keep the difference, quotient bit 1.
         // A zero divisor always fits, giving all-ones quotient and remainder=dividend.
         if (!div_diff[WIDTH+1]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

`ifdef SM_MULDIV_SIGNED_EN
   // Sign correction of the magnitude result
   always_comb begin
      prod_neg = -{acc_hi, acc_lo};
      fix_hi   = acc_hi;
      fix_lo   = acc_lo;
      if (op_div) begin
         if (neg_r) fix_hi = -acc_hi;
         if (dz_pend) begin
            fix_lo = '1;
         end else if (neg_q) begin
            fix_lo = -acc_lo;
         end
      end else if (neg_q) begin
         fix_hi = prod_neg[2*WIDTH-1:WIDTH];
         fix_lo = prod_neg[WIDTH-1:0];
      end
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) state_next = CALC;
         end
         CALC: begin
            if (cnt == LAST_ITER) begin
               state_next = fix_needed ? FIX : IDLE;
            end
         end
         FIX: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         divZero <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         cnt     <= '0;
         op_div  <= 1'b0;
         dz_pend <= 1'b0;
         opb     <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
`ifdef SM_MULDIV_SIGNED_EN
         op_signed <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // Start wins over simultaneous direct writes
                  busy    <= 1'b1;
                  divZero <= 1'b0;
                  cnt     <= '0;
                  op_div  <= ld_div;
                  dz_pend <= ld_div && (srcB == '0);
                  opb     <= ld_b;
                  acc_hi  <= '0;
                  acc_lo  <= ld_a;
`ifdef SM_MULDIV_SIGNED_EN
                  op_signed <= ld_signed;
                  neg_q     <= ld_a_neg ^ ld_b_neg;
                  neg_r     <= ld_a_neg;
`endif
               end else begin
                  if (hiWe) hi <= wData;
                  if (loWe) lo <= wData;
               end
            end
            CALC: begin
               cnt    <= cnt + CW'(1);
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               if ((cnt == LAST_ITER) && !fix_needed) begin
                  hi      <= step_hi;
                  lo      <= step_lo;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  divZero <= dz_pend;
               end
            end
            FIX: begin
`ifdef SM_MULDIV_SIGNED_EN
               hi <= fix_hi;
               lo <= fix_lo;
`endif
               busy    <= 1'b0;
               done    <= 1'b1;
               divZero <= dz_pend;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/sm_muldiv.md
SM_MULDIV -- requirements
Module: sm_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are even and 4..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only while busy=0.
REQ-005 SHALL have port oper  input  2  operation select: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
REQ-006 SHALL have port srcA  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL have port srcB  input  WIDTH  multiplier or divisor.
REQ-008 SHALL have port hiWe  input  1  direct write of hi from wData (MTHI).
REQ-009 SHALL have port loWe  input  1  direct write of lo from wData (MTLO).
REQ-010 SHALL have port wData  input  WIDTH  direct-write data.
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse on result completion.
REQ-013 SHALL have port divZero  output  1  the last division had divisor 0.
REQ-014 SHALL have port hi  output  WIDTH  product upper half or remainder.
REQ-015 SHALL have port lo  output  WIDTH  product lower half or quotient.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, FIX: IDLE->CALC on accepted start; CALC->FIX after WIDTH iterations for signed ops; CALC->IDLE for unsigned ops; FIX->IDLE after 1 cycle.
REQ-017 SHALL accept start only in IDLE; operands and oper are latched on the accepting edge, and later input changes have no effect.
REQ-018 SHALL compute MULTU by radix-2 shift-add, one bit per cycle; {hi,lo} is the full 2*WIDTH-bit product.
REQ-019 SHALL compute DIVU by restoring division, one bit per cycle; lo is the quotient and hi is the remainder.
REQ-020 SHALL hold busy=1 for exactly WIDTH cycles after the accepting edge for unsigned ops, and WIDTH+1 cycles for signed ops.
REQ-021 SHALL update hi/lo on the same edge that deasserts busy, and assert done for exactly the first cycle with busy=0.
REQ-022 SHALL hold hi/lo stable between completions except for direct writes.
REQ-023 SHALL ignore start, hiWe and loWe while busy=1.
REQ-024 SHALL give start priority over hiWe/loWe when they coincide in IDLE; the writes are dropped.
REQ-025 SHALL apply a direct write on the edge where it is sampled; hiWe and loWe together write both registers.
REQ-026 SHALL, when the divisor is 0, return lo=all ones and hi=dividend, and set divZero on completion.
REQ-027 SHALL hold divZero until the next accepted start, then clear it.
REQ-028 SHALL allow back-to-back operation: a start in the done cycle is accepted.

Reset
REQ-029 SHALL, on rst_n=0, immediately and regardless of state, force IDLE, busy=0, done=0, divZero=0, hi=0, lo=0.
REQ-030 SHALL abort an in-flight operation on reset mid-operation, with no result update after release.

Configuration
REQ-031 SHALL, with macro SM_MULDIV_SIGNED_EN defined, implement MULT/DIV by operating on magnitudes and applying sign correction in the FIX state.
REQ-032 SHALL, in signed division, give the remainder the sign of the dividend and truncate the quotient toward zero.
REQ-033 SHALL, in signed division, return lo=MIN and hi=0 for MIN/-1.
REQ-034 SHALL, in signed division by 0, return lo=all ones and hi=dividend.
REQ-035 SHALL, without SM_MULDIV_SIGNED_EN, ignore oper[1], execute every op as unsigned, and never enter FIX.

Verification (WIDTH=32)
REQ-036 SHALL cover: MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, busy high exactly 32 cycles, done 1 cycle.
REQ-037 SHALL cover: DIVU 100/7 -> lo=14, hi=2, divZero=0; an immediate second start in the done cycle is accepted.
REQ-038 SHALL cover: DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, divZero=1; divZero stays 1 until the next start, then clears.
REQ-039 SHALL cover: start and hiWe pulsed at cycle 5 of a MULTU 3*4 -> both ignored, hi=0, lo=12; rst_n low at cycle 10 of a second op -> busy=0, hi=lo=0, no done.
REQ-040 SHALL cover, with the macro: DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy 33 cycles; MULT -2*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-041 SHALL cover, without the macro: oper=11 with 0xFFFFFFF9/2 -> lo=0x7FFFFFFC, hi=1, busy 32 cycles.
